round_key_scheduler: RTL and testbench
======================================

# round_key_scheduler

- Iterative, parametrised AES key-expansion engine for AES-128/192/256.
- On a load request it computes the full FIPS-197 expanded key at one 32-bit word per cycle and stores it in an internal round-key register file.
- It then serves the 128-bit round key selected by round index and direction to the cipher/inverse-cipher datapath.
- It replaces the combinational all-rounds key expander used by the existing 128-bit encrypt/decrypt core.

## Interface
Parameters:
- KEY_BITS, 128: cipher key length; legal values are 128, 192 and 256. Derived values: NK = KEY_BITS/32; NR = NK+6; NW = 4*(NR+1).

Ports:
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  KEY_BITS  cipher key; w[0] = key_in[KEY_BITS-1 -: 32].
- key_load  in  1  single-cycle strobe that captures key_in and starts expansion.
- mode  in  1  1 = encrypt, 0 = decrypt.
- round_idx  in  4  round counter from the cipher control FSM.
- curr_key  out  128  selected round key, registered.
- busy  out  1  high while expansion is in progress.
- keys_ready  out  1  high when the whole schedule is valid.

## Operation
- States:
  - IDLE → EXPAND on key_load.
  - EXPAND → READY after writing w[NW-1].
  - READY → EXPAND on key_load.
  - EXPAND → EXPAND (restart) on key_load: the running expansion is aborted and the new key captured.
- Load edge: w[0..NK-1] ← key_in; word counter i ← NK; keys_ready ← 0.
- Each EXPAND cycle writes one word w[i], then i ← i+1:
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- The i mod NK and i/NK values come from a separate modulo counter and Rcon index register; no divider is used.
- Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
- Key selection: index k = mode ? round_idx : NR − round_idx.
  - If round_idx > NR or keys_ready == 0, curr_key ← 0.
  - Otherwise curr_key ← round key k.
- Precedence: rst beats key_load in the same cycle.
- round_idx and mode are ignored while busy; curr_key is forced to 0.

## Timing
- Reset values: state IDLE, busy 0, keys_ready 0, curr_key 0, all stored words 0.
- busy rises the cycle after the load edge and stays high for NW−NK cycles.
- keys_ready rises in the same cycle busy falls: 40 / 46 / 52 cycles after the load edge for KEY_BITS 128 / 192 / 256.
- curr_key latency: one cycle from a change of round_idx or mode.
- A key_load during EXPAND restarts the count at NK; the total latency is measured from the last load edge.
- rst mid-expansion: the next cycle is IDLE and the words are zeroed.

## Configuration
- KEYSCHED_ZEROIZE_EN:
  - Defined: adds input port zeroize (1 bit).
  - Asserting zeroize clears all stored words, clears curr_key, drops keys_ready and returns the FSM to IDLE in one cycle.
  - rst beats zeroize; zeroize beats key_load.
- Undefined: the port is absent, and key material persists until rst or the next load.

## Structure
- Shared package aes_pkg holds:
  - state enum (IDLE, EXPAND, READY);
  - the Rcon constant array (10 entries);
  - the S-box constant table;
  - word_t (logic [31:0]) and rkey_t (logic [127:0]) typedefs.
- Sub-module sub_word: four parallel S-box lookups on a 32-bit word, purely combinational.
- The top level holds the FSM, the counters, the NW×32 register file and the output mux/register.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, load. Required: keys_ready exactly 40 cycles later; mode=1, round_idx=1 → curr_key a0fafe1788542cb123a339392a6c7605; round_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, mode=0, round_idx=0 → d014f9a8c9ee2589e13f0cc8b6630ca6 (decrypt order reversed); round_idx=11 → 0.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b. Required: keys_ready after 46 cycles; mode=1, round_idx=12 → e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4. Required: keys_ready after 52 cycles; mode=1, round_idx=14 → fe4890d1e6188d0b046df344706c631e.
- Abort and reset case:
  - Load key A, then load the 128-bit key of the first scenario at cycle 20 of the expansion. Required: keys_ready 40 cycles after the second load, with the same round-10 key as the first scenario.
  - Assert rst at cycle 10 of an expansion. Required: busy 0 and curr_key 0 on the next cycle.
- With KEYSCHED_ZEROIZE_EN defined: after keys_ready, pulse zeroize. Required: keys_ready 0 and curr_key 0 next cycle; IDLE; a fresh load re-expands correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM states, Rcon and S-box tables
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Entry n holds Rcon[n+1]
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sub_word.sv
// rtl/sub_word.sv - four parallel S-box lookups on one 32-bit word
module sub_word
    import aes_pkg::*;
(
    input  word_t in_word,
    output word_t out_word
);

    assign out_word[31:24] = sbox(in_word[31:24]);
    assign out_word[23:16] = sbox(in_word[23:16]);
    assign out_word[15:8]  = sbox(in_word[15:8]);
    assign out_word[7:0]   = sbox(in_word[7:0]);

endmodule

// File: rtl/round_key_scheduler.sv
// rtl/round_key_scheduler.sv - iterative AES-128/192/256 key expansion with round key select (optional KEYSCHED_ZEROIZE_EN)
module round_key_scheduler
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_load,
    input  logic                mode,
    input  logic [3:0]          round_idx,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic                zeroize,
`endif
    output rkey_t               curr_key,
    output logic                busy,
    output logic                keys_ready
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);

    state_t          state;
    state_t          state_nxt;
    word_t           words [NW];
    logic [IW-1:0]   wr_idx;
    logic [2:0]      mod_cnt;
    logic [3:0]      rcon_idx;
    logic            clear;
    logic            last_word;

    word_t           prev_word;
    word_t           base_word;
    word_t           sw_in;
    word_t           sw_out;
    word_t           temp;
    word_t           new_word;
    logic [7:0]      rcon_byte;

    logic [3:0]      sel;
    logic [IW-1:0]   sel_base;
    rkey_t           key_sel;

`ifdef KEYSCHED_ZEROIZE_EN
    assign clear = zeroize;
`else
    assign clear = 1'b0;
`endif

    assign busy      = (state == EXPAND);
    assign last_word = (wr_idx == IW'(NW - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_load) state_nxt = EXPAND;
            EXPAND:  if (key_load) state_nxt = EXPAND;
                     else if (last_word) state_nxt = READY;
            READY:   if (key_load) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // wr_idx never drops below NK, so both reads stay inside the file
    assign prev_word = words[wr_idx - IW'(1)];
    assign base_word = words[wr_idx - IW'(NK)];
    assign rcon_byte = RCON[rcon_idx - 4'd1];
    assign sw_in     = (mod_cnt == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    sub_word u_sub_word (
        .in_word  (sw_in),
        .out_word (sw_out)
    );

    always_comb begin
        temp = prev_word;
        if (mod_cnt == 3'd0)
            temp = sw_out ^ {rcon_byte, 24'h0};
        else if (NK == 8 && mod_cnt == 3'd4)
            temp = sw_out;
    end

    assign new_word = base_word ^ temp;

    always_comb begin
        key_sel  = '0;
        sel      = mode ? round_idx : 4'(NR) - round_idx;
        sel_base = IW'({sel, 2'b00});
        if (keys_ready && !busy && round_idx <= 4'(NR))
            key_sel = {words[sel_base], words[sel_base + IW'(1)],
                       words[sel_base + IW'(2)], words[sel_base + IW'(3)]};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            wr_idx     <= IW'(NK);
            mod_cnt    <= 3'd0;
            rcon_idx   <= 4'd1;
            keys_ready <= 1'b0;
            curr_key   <= '0;
            for (int n = 0; n < NW; n++) words[n] <= '0;
        end else begin
            state    <= state_nxt;
            curr_key <= key_sel;
            if (key_load) begin
                for (int n = 0; n < NK; n++) words[n] <= key_in[KEY_BITS-1-32*n -: 32];
                wr_idx     <= IW'(NK);
                mod_cnt    <= 3'd0;
                rcon_idx   <= 4'd1;
                keys_ready <= 1'b0;
            end else if (state == EXPAND) begin
                words[wr_idx] <= new_word;
                if (last_word) keys_ready <= 1'b1;
                else           wr_idx     <= wr_idx + IW'(1);
                // mod_cnt tracks i mod NK, rcon_idx tracks i / NK
                if (mod_cnt == 3'(NK - 1)) begin
                    mod_cnt  <= 3'd0;
                    rcon_idx <= rcon_idx + 4'd1;
                end else begin
                    mod_cnt <= mod_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_key_scheduler.sv
// tb/tb_round_key_scheduler.sv - scoreboard bench for round_key_scheduler (KEYSCHED_ZEROIZE_EN optional)
module tb_round_key_scheduler;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic         m;
        logic [3:0]   r;
        logic [127:0] e;
    } req_t;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [3:0]   round_idx;
    logic         ld128, ld192, ld256;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [127:0] ck128, ck192, ck256;
    logic         busy128, busy192, busy256;
    logic         rdy128, rdy192, rdy256;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int           n_checks;
    int           n_fail;
    logic [127:0] exp_q [$];

    round_key_scheduler #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .key_in(key128), .key_load(ld128), .mode(mode), .round_idx(round_idx),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .curr_key(ck128), .busy(busy128), .keys_ready(rdy128)
    );

    round_key_scheduler #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .key_in(key192), .key_load(ld192), .mode(mode), .round_idx(round_idx),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .curr_key(ck192), .busy(busy192), .keys_ready(rdy192)
    );

    round_key_scheduler #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .key_in(key256), .key_load(ld256), .mode(mode), .round_idx(round_idx),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .curr_key(ck256), .busy(busy256), .keys_ready(rdy256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load128(input logic [127:0] k, output int cnt);
        key128 = k;
        ld128  = 1'b1;
        @(posedge clk); #1;
        ld128 = 1'b0;
        n_checks++;
        if (busy128 !== 1'b1 || rdy128 !== 1'b0) begin
            n_fail++;
            $display("FAIL load128_busy: busy=%b ready=%b required busy=1 ready=0", busy128, rdy128);
        end
        cnt = 0;
        while (rdy128 !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy128, busy192, busy256} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 000", {busy128, busy192, busy256});
        end
        n_checks++;
        if ({rdy128, rdy192, rdy256} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 000", {rdy128, rdy192, rdy256});
        end
        n_checks++;
        if ((ck128 | ck192 | ck256) !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_curr_key: got %h %h %h required all zero", ck128, ck192, ck256);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_aes128;
        int   cnt;
        req_t reqs [9];
        load128(K128, cnt);
        n_checks++;
        if (cnt !== 40 || busy128 !== 1'b0) begin
            n_fail++;
            $display("FAIL aes128_latency: cycles=%0d busy=%b required 40 and busy=0", cnt, busy128);
        end
        reqs = '{'{1'b1, 4'd1, R128_1}, '{1'b1, 4'd10, R128_10}, '{1'b1, 4'd2, R128_2},
                 '{1'b1, 4'd0, K128}, '{1'b0, 4'd0, R128_10}, '{1'b0, 4'd10, K128},
                 '{1'b0, 4'd11, 128'h0}, '{1'b1, 4'd11, 128'h0}, '{1'b1, 4'd15, 128'h0}};
        foreach (reqs[i]) begin
            mode      = reqs[i].m;
            round_idx = reqs[i].r;
            exp_q.push_back(reqs[i].e);
            @(posedge clk); #1;
            begin
                logic [127:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (ck128 !== e) begin
                    n_fail++;
                    $display("FAIL aes128_key[%0d] mode=%b idx=%0d: got %h required %h", i, reqs[i].m, reqs[i].r, ck128, e);
                end
            end
        end
    endtask

    task automatic test_aes192;
        int   cnt;
        req_t reqs [3];
        key192 = K192;
        ld192  = 1'b1;
        @(posedge clk); #1;
        ld192 = 1'b0;
        cnt = 0;
        while (rdy192 !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt !== 46) begin
            n_fail++;
            $display("FAIL aes192_latency: cycles=%0d required 46", cnt);
        end
        reqs = '{'{1'b1, 4'd12, R192_12}, '{1'b1, 4'd0, R192_0}, '{1'b0, 4'd0, R192_12}};
        foreach (reqs[i]) begin
            mode      = reqs[i].m;
            round_idx = reqs[i].r;
            exp_q.push_back(reqs[i].e);
            @(posedge clk); #1;
            begin
                logic [127:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (ck192 !== e) begin
                    n_fail++;
                    $display("FAIL aes192_key[%0d]: got %h required %h", i, ck192, e);
                end
            end
        end
    endtask

    task automatic test_aes256;
        int   cnt;
        req_t reqs [5];
        key256 = K256;
        ld256  = 1'b1;
        @(posedge clk); #1;
        ld256 = 1'b0;
        cnt = 0;
        while (rdy256 !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt !== 52) begin
            n_fail++;
            $display("FAIL aes256_latency: cycles=%0d required 52", cnt);
        end
        reqs = '{'{1'b1, 4'd14, R256_14}, '{1'b1, 4'd0, R256_0}, '{1'b1, 4'd1, R256_1},
                 '{1'b0, 4'd14, R256_0}, '{1'b0, 4'd0, R256_14}};
        foreach (reqs[i]) begin
            mode      = reqs[i].m;
            round_idx = reqs[i].r;
            exp_q.push_back(reqs[i].e);
            @(posedge clk); #1;
            begin
                logic [127:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (ck256 !== e) begin
                    n_fail++;
                    $display("FAIL aes256_key[%0d]: got %h required %h", i, ck256, e);
                end
            end
        end
    endtask

    task automatic test_abort;
        int cnt;
        key128 = KEY_A;
        ld128  = 1'b1;
        @(posedge clk); #1;
        ld128     = 1'b0;
        mode      = 1'b1;
        round_idx = 4'd0;
        exp_q.push_back(128'h0);
        repeat (4) @(posedge clk);
        #1;
        begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (ck128 !== e) begin
                n_fail++;
                $display("FAIL busy_gate_curr_key: got %h required %h", ck128, e);
            end
        end
        repeat (15) @(posedge clk);
        #1;
        load128(K128, cnt);
        n_checks++;
        if (cnt !== 40) begin
            n_fail++;
            $display("FAIL abort_latency: cycles=%0d required 40", cnt);
        end
        round_idx = 4'd10;
        exp_q.push_back(R128_10);
        @(posedge clk); #1;
        begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (ck128 !== e) begin
                n_fail++;
                $display("FAIL abort_round10: got %h required %h", ck128, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        load128(K128, cnt);
        n_checks++;
        if (cnt !== 40) begin
            n_fail++;
            $display("FAIL reload_latency: cycles=%0d required 40", cnt);
        end
        mode      = 1'b1;
        round_idx = 4'd1;
        exp_q.push_back(R128_1);
        @(posedge clk); #1;
        begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (ck128 !== e) begin
                n_fail++;
                $display("FAIL reload_round1: got %h required %h", ck128, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        key128 = K128;
        ld128  = 1'b1;
        @(posedge clk); #1;
        ld128 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy128 !== 1'b0 || rdy128 !== 1'b0 || ck128 !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b ready=%b key=%h required 0 0 0", busy128, rdy128, ck128);
        end
        mode      = 1'b1;
        round_idx = 4'd0;
        exp_q.push_back(128'h0);
        repeat (3) @(posedge clk);
        #1;
        begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (ck128 !== e || busy128 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_idle: key=%h busy=%b required %h busy=0", ck128, busy128, e);
            end
        end
    endtask

`ifdef KEYSCHED_ZEROIZE_EN
    task automatic test_zeroize;
        int cnt;
        load128(K128, cnt);
        mode      = 1'b1;
        round_idx = 4'd10;
        @(posedge clk); #1;
        zeroize = 1'b1;
        ld128   = 1'b1;
        key128  = KEY_A;
        @(posedge clk); #1;
        zeroize = 1'b0;
        ld128   = 1'b0;
        n_checks++;
        if (rdy128 !== 1'b0 || ck128 !== 128'h0 || busy128 !== 1'b0) begin
            n_fail++;
            $display("FAIL zeroize_clear: ready=%b key=%h busy=%b required 0 0 0", rdy128, ck128, busy128);
        end
        load128(K128, cnt);
        n_checks++;
        if (cnt !== 40) begin
            n_fail++;
            $display("FAIL zeroize_reload_latency: cycles=%0d required 40", cnt);
        end
        exp_q.push_back(R128_10);
        @(posedge clk); #1;
        begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (ck128 !== e) begin
                n_fail++;
                $display("FAIL zeroize_reload_key: got %h required %h", ck128, e);
            end
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        mode      = 1'b1;
        round_idx = 4'd0;
        ld128     = 1'b0;
        ld192     = 1'b0;
        ld256     = 1'b0;
        key128    = '0;
        key192    = '0;
        key256    = '0;
`ifdef KEYSCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef KEYSCHED_ZEROIZE_EN
        test_zeroize();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
